// File: rtl/reset_sequencer.sv
// reset_sequencer: merges the power-on reset with soft-reset requests and
// drives N_DOMAINS reset outputs. All outputs are held together for
// HOLD_CYCLES, then released one at a time in index order, STAGGER_CYCLES
// apart. rst_cause records which sources triggered the current or last sequence.
module reset_sequencer #(
    parameter int          N_DOMAINS      = 4,
    parameter int          N_REQ          = 2,
    parameter logic [7:0]  HOLD_CYCLES    = 8'hFA,
    parameter logic [7:0]  STAGGER_CYCLES = 8'd25
) (
    input  logic                 clk_25,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     soft_rst_req,
    output logic [N_DOMAINS-1:0] rst_out,
    output logic                 rst_done,
    output logic [N_REQ:0]       rst_cause
);

    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic                 rst_done_q, rst_done_d;
    logic [N_REQ:0]       rst_cause_q, rst_cause_d;

    logic                 req_any;
    logic [N_REQ:0]       req_cause;

    assign req_any   = |soft_rst_req;
    assign req_cause = {soft_rst_req, 1'b0};

    // Next-state logic: hold count, staggered release, restart on request.
    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a variable unassigned, which would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rst_out_d   = rst_out_q;
        rst_done_d  = rst_done_q;
        rst_cause_d = rst_cause_q;

        case (state_q)
            ST_ASSERT: begin
                rst_cause_d = rst_cause_q | req_cause;
                if (req_any) begin
                    // A held request keeps stretching the hold period.
                    cnt_d = HOLD_CYCLES - 8'd1;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    rst_out_d[0] = 1'b0;
                    idx_d        = IDX_W'(1);
                    cnt_d        = STAGGER_CYCLES - 8'd1;
                    if (N_DOMAINS == 1) begin
                        rst_done_d = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        state_d    = ST_RELEASE;
                    end
                end
            end

            ST_RELEASE: begin
                rst_cause_d = rst_cause_q | req_cause;
                if (req_any) begin
                    // Restart: domains already released go back into reset.
                    state_d   = ST_ASSERT;
                    rst_out_d = {N_DOMAINS{1'b1}};
                    cnt_d     = HOLD_CYCLES - 8'd1;
                    idx_d     = '0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    for (int i = 0; i < N_DOMAINS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            rst_out_d[i] = 1'b0;
                        end
                    end
                    cnt_d = STAGGER_CYCLES - 8'd1;
                    if (idx_q == IDX_W'(N_DOMAINS - 1)) begin
                        rst_done_d = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            ST_RUN: begin
                if (req_any) begin
                    // A new sequence starts; the previous cause is discarded.
                    state_d     = ST_ASSERT;
                    rst_out_d   = {N_DOMAINS{1'b1}};
                    rst_done_d  = 1'b0;
                    cnt_d       = HOLD_CYCLES - 8'd1;
                    idx_d       = '0;
                    rst_cause_d = req_cause;
                end
            end

            default: begin
                // Unused encoding: fall back into a full reset sequence.
                state_d    = ST_ASSERT;
                rst_out_d  = {N_DOMAINS{1'b1}};
                rst_done_d = 1'b0;
                cnt_d      = HOLD_CYCLES - 8'd1;
                idx_d      = '0;
            end
        endcase
    end

    // State registers with synchronous power-on reset taking priority over requests.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= HOLD_CYCLES - 8'd1;
            idx_q       <= '0;
            rst_out_q   <= {N_DOMAINS{1'b1}};
            rst_done_q  <= 1'b0;
            rst_cause_q <= {{N_REQ{1'b0}}, 1'b1};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rst_out_q   <= rst_out_d;
            rst_done_q  <= rst_done_d;
            rst_cause_q <= rst_cause_d;
        end
    end

    assign rst_out   = rst_out_q;
    assign rst_done  = rst_done_q;
    assign rst_cause = rst_cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer with N_DOMAINS=3, N_REQ=2, HOLD=4, STAGGER=2.
// Per-edge expectations come from a timing model (edges since the last
// anchoring edge) and pass through a scoreboard queue; each phase of the
// vector table also carries hand-derived end-of-phase values.
module tb_reset_sequencer;

    localparam int         ND     = 3;
    localparam int         NR     = 2;
    localparam logic [7:0] HOLD   = 8'd4;
    localparam logic [7:0] STAG   = 8'd2;
    localparam int         DONE_T = 4 + (ND - 1) * 2;

    logic          clk_25 = 1'b0;
    logic          reset  = 1'b1;
    logic [NR-1:0] soft_rst_req = '0;
    logic [ND-1:0] rst_out;
    logic          rst_done;
    logic [NR:0]   rst_cause;

    reset_sequencer #(
        .N_DOMAINS      (ND),
        .N_REQ          (NR),
        .HOLD_CYCLES    (HOLD),
        .STAGGER_CYCLES (STAG)
    ) dut (
        .clk_25       (clk_25),
        .reset        (reset),
        .soft_rst_req (soft_rst_req),
        .rst_out      (rst_out),
        .rst_done     (rst_done),
        .rst_cause    (rst_cause)
    );

    initial forever #20 clk_25 = ~clk_25;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Timing model: t_m counts edges since the last anchoring edge.
    int          t_m = 0;
    logic [NR:0] cause_m = 3'b001;

    typedef struct {
        logic [ND-1:0] out;
        logic          done;
        logic [NR:0]   cause;
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t model_edge(input logic r, input logic [NR-1:0] q);
        exp_t e;
        if (r) begin
            t_m     = 0;
            cause_m = 3'b001;
        end else if (q != '0) begin
            if (t_m >= DONE_T) cause_m = {q, 1'b0};
            else               cause_m = cause_m | {q, 1'b0};
            t_m = 0;
        end else if (t_m < DONE_T) begin
            t_m++;
        end
        for (int i = 0; i < ND; i++) begin
            e.out[i] = (t_m < int'(HOLD) + i * int'(STAG));
        end
        e.done  = (t_m >= DONE_T);
        e.cause = cause_m;
        return e;
    endfunction

    // One clock: drive on the falling edge, push the expectation at the
    // rising edge, compare just after it.
    task automatic step(input logic r, input logic [NR-1:0] q, input string tag);
        exp_t e;
        @(negedge clk_25);
        reset        = r;
        soft_rst_req = q;
        @(posedge clk_25);
        sb_q.push_back(model_edge(r, q));
        #1;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, " rst_out"},   32'(rst_out),   32'(e.out));
            check({tag, " rst_done"},  32'(rst_done),  32'(e.done));
            check({tag, " rst_cause"}, 32'(rst_cause), 32'(e.cause));
        end
    endtask

    typedef struct {
        logic          r;
        logic [NR-1:0] q;
        int            n;
        logic [ND-1:0] e_out;
        logic          e_done;
        logic [NR:0]   e_cause;
    } vec_t;

    vec_t vecs[22];

    initial begin
        // Power-on
        vecs[0]  = '{1'b1, 2'b00, 3,  3'b111, 1'b0, 3'b001};
        vecs[1]  = '{1'b0, 2'b00, 10, 3'b000, 1'b1, 3'b001};
        // Soft pulse from RUN
        vecs[2]  = '{1'b0, 2'b01, 1,  3'b111, 1'b0, 3'b010};
        vecs[3]  = '{1'b0, 2'b00, 8,  3'b000, 1'b1, 3'b010};
        // Held request for 10 cycles, then release boundary at +4
        vecs[4]  = '{1'b0, 2'b10, 10, 3'b111, 1'b0, 3'b100};
        vecs[5]  = '{1'b0, 2'b00, 3,  3'b111, 1'b0, 3'b100};
        vecs[6]  = '{1'b0, 2'b00, 1,  3'b110, 1'b0, 3'b100};
        vecs[7]  = '{1'b0, 2'b00, 4,  3'b000, 1'b1, 3'b100};
        // Restart mid-release, single cause
        vecs[8]  = '{1'b0, 2'b01, 1,  3'b111, 1'b0, 3'b010};
        vecs[9]  = '{1'b0, 2'b00, 4,  3'b110, 1'b0, 3'b010};
        vecs[10] = '{1'b0, 2'b01, 1,  3'b111, 1'b0, 3'b010};
        vecs[11] = '{1'b0, 2'b00, 8,  3'b000, 1'b1, 3'b010};
        // Restart mid-release after req1 started the sequence
        vecs[12] = '{1'b0, 2'b10, 1,  3'b111, 1'b0, 3'b100};
        vecs[13] = '{1'b0, 2'b00, 5,  3'b110, 1'b0, 3'b100};
        vecs[14] = '{1'b0, 2'b01, 1,  3'b111, 1'b0, 3'b110};
        vecs[15] = '{1'b0, 2'b00, 8,  3'b000, 1'b1, 3'b110};
        // Simultaneous requests
        vecs[16] = '{1'b0, 2'b11, 1,  3'b111, 1'b0, 3'b110};
        vecs[17] = '{1'b0, 2'b00, 8,  3'b000, 1'b1, 3'b110};
        // Reset priority mid-release
        vecs[18] = '{1'b0, 2'b01, 1,  3'b111, 1'b0, 3'b010};
        vecs[19] = '{1'b0, 2'b00, 6,  3'b100, 1'b0, 3'b010};
        vecs[20] = '{1'b1, 2'b11, 2,  3'b111, 1'b0, 3'b001};
        vecs[21] = '{1'b0, 2'b00, 8,  3'b000, 1'b1, 3'b001};

        for (int k = 0; k < 22; k++) begin
            for (int c = 0; c < vecs[k].n; c++) begin
                step(vecs[k].r, vecs[k].q, $sformatf("v%0d c%0d", k, c));
            end
            check($sformatf("v%0d end rst_out", k),   32'(rst_out),   32'(vecs[k].e_out));
            check($sformatf("v%0d end rst_done", k),  32'(rst_done),  32'(vecs[k].e_done));
            check($sformatf("v%0d end rst_cause", k), 32'(rst_cause), 32'(vecs[k].e_cause));
        end

        // Hand-written corner: request held across the exact release edge.
        // Three idle edges, then a request on what would be edge 4 in ASSERT.
        step(1'b0, 2'b01, "hold c0");
        step(1'b0, 2'b00, "hold c1");
        step(1'b0, 2'b00, "hold c2");
        step(1'b0, 2'b00, "hold c3");
        step(1'b0, 2'b10, "hold edge4 req");
        check("hold edge4 rst_out", 32'(rst_out), 32'(3'b111));
        check("hold edge4 cause", 32'(rst_cause), 32'(3'b110));
        for (int c = 0; c < 4; c++) step(1'b0, 2'b00, "hold tail");
        check("hold tail rst_out", 32'(rst_out), 32'(3'b110));

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
